// File: rtl/execute_stage_if.sv
// Bundle between the ID/EX register, hazard unit, execute stage and EX/MEM consumers.
// The master side drives ID/EX values and forwarding selects; the execute stage is the slave.
interface execute_stage_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] RD1;
   logic [WIDTH-1:0] RD2;
   logic [4:0]       RtE;
   logic [4:0]       RdE;
   logic [WIDTH-1:0] SignImmE;
   logic             RegWriteE;
   logic             MemtoRegE;
   logic             MemWriteE;
   logic [2:0]       ALUControlE;
   logic             ALUSrcE;
   logic             RegDstE;
   logic [1:0]       ForwardAE;
   logic [1:0]       ForwardBE;
   logic [WIDTH-1:0] ResultW;
   logic [4:0]       WriteRegE;
   logic             RegWriteM;
   logic             MemtoRegM;
   logic             MemWriteM;
   logic [WIDTH-1:0] ALUOutM;
   logic [WIDTH-1:0] WriteDataM;
   logic [4:0]       WriteRegM;

   modport master (
      output RD1, RD2, RtE, RdE, SignImmE,
      output RegWriteE, MemtoRegE, MemWriteE, ALUControlE, ALUSrcE, RegDstE,
      output ForwardAE, ForwardBE, ResultW,
      input  WriteRegE, RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM
   );

   modport slave (
      input  RD1, RD2, RtE, RdE, SignImmE,
      input  RegWriteE, MemtoRegE, MemWriteE, ALUControlE, ALUSrcE, RegDstE,
      input  ForwardAE, ForwardBE, ResultW,
      output WriteRegE, RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM
   );
endinterface

// File: rtl/execute_stage.sv
// MIPS EX stage: operand forwarding, ALUSrc mux, ALU and destination select,
// captured every cycle into the EX/MEM pipeline register.
module execute_stage #(
   parameter int WIDTH = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   execute_stage_if.slave  ex
);

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   function automatic logic [WIDTH-1:0] alu_calc(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b
   );
      logic [WIDTH-1:0] r;
      case (op)
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_ADD: r = a + b;
         ALU_SUB: r = a - b;
         ALU_SLT: r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         default: r = {WIDTH{1'b0}};
      endcase
      return r;
   endfunction

   // Select 2'b11 deliberately falls back to the register-file value.
   function automatic logic [WIDTH-1:0] fwd_mux(
      input logic [1:0]       sel,
      input logic [WIDTH-1:0] rf_val,
      input logic [WIDTH-1:0] wb_val,
      input logic [WIDTH-1:0] mem_val
   );
      logic [WIDTH-1:0] r;
      case (sel)
         2'b01:   r = wb_val;
         2'b10:   r = mem_val;
         default: r = rf_val;
      endcase
      return r;
   endfunction

   logic [WIDTH-1:0] src_a_s;
   logic [WIDTH-1:0] fwd_b_s;
   logic [WIDTH-1:0] src_b_s;
   logic [WIDTH-1:0] alu_res_s;
   logic [4:0]       write_reg_s;

   logic             reg_write_q,  reg_write_d;
   logic             mem_to_reg_q, mem_to_reg_d;
   logic             mem_write_q,  mem_write_d;
   logic [WIDTH-1:0] alu_out_q,    alu_out_d;
   logic [WIDTH-1:0] write_data_q, write_data_d;
   logic [4:0]       write_reg_q,  write_reg_d;

   // Operand forwarding, ALUSrc select, ALU and destination register.
   always_comb begin
      src_a_s   = fwd_mux(ex.ForwardAE, ex.RD1, ex.ResultW, alu_out_q);
      fwd_b_s   = fwd_mux(ex.ForwardBE, ex.RD2, ex.ResultW, alu_out_q);
      if (ex.ALUSrcE) begin
         src_b_s = ex.SignImmE;
      end else begin
         src_b_s = fwd_b_s;
      end
      alu_res_s = alu_calc(ex.ALUControlE, src_a_s, src_b_s);
      if (ex.RegDstE) begin
         write_reg_s = ex.RdE;
      end else begin
         write_reg_s = ex.RtE;
      end
   end

   // EX/MEM next state: loads unconditionally each cycle.
   always_comb begin
      reg_write_d  = ex.RegWriteE;
      mem_to_reg_d = ex.MemtoRegE;
      mem_write_d  = ex.MemWriteE;
      alu_out_d    = alu_res_s;
      write_data_d = fwd_b_s;
      write_reg_d  = write_reg_s;
   end

   // EX/MEM pipeline register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         mem_write_q  <= 1'b0;
         alu_out_q    <= {WIDTH{1'b0}};
         write_data_q <= {WIDTH{1'b0}};
         write_reg_q  <= 5'd0;
      end else begin
         reg_write_q  <= reg_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         mem_write_q  <= mem_write_d;
         alu_out_q    <= alu_out_d;
         write_data_q <= write_data_d;
         write_reg_q  <= write_reg_d;
      end
   end

   assign ex.WriteRegE  = write_reg_s;
   assign ex.RegWriteM  = reg_write_q;
   assign ex.MemtoRegM  = mem_to_reg_q;
   assign ex.MemWriteM  = mem_write_q;
   assign ex.ALUOutM    = alu_out_q;
   assign ex.WriteDataM = write_data_q;
   assign ex.WriteRegM  = write_reg_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage with hand-computed expected values.
module tb_execute_stage;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fails;

   execute_stage_if #(.WIDTH(32)) ex_if ();

   execute_stage #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ex    (ex_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      ex_if.RD1         = 32'd0;
      ex_if.RD2         = 32'd0;
      ex_if.RtE         = 5'd0;
      ex_if.RdE         = 5'd0;
      ex_if.SignImmE    = 32'd0;
      ex_if.RegWriteE   = 1'b0;
      ex_if.MemtoRegE   = 1'b0;
      ex_if.MemWriteE   = 1'b0;
      ex_if.ALUControlE = 3'b000;
      ex_if.ALUSrcE     = 1'b0;
      ex_if.RegDstE     = 1'b0;
      ex_if.ForwardAE   = 2'b00;
      ex_if.ForwardBE   = 2'b00;
      ex_if.ResultW     = 32'd0;
   endtask

   task automatic check_m_zero(input string tag);
      check_val({tag, "_RegWriteM"},  {31'd0, ex_if.RegWriteM}, 32'd0);
      check_val({tag, "_MemtoRegM"},  {31'd0, ex_if.MemtoRegM}, 32'd0);
      check_val({tag, "_MemWriteM"},  {31'd0, ex_if.MemWriteM}, 32'd0);
      check_val({tag, "_ALUOutM"},    ex_if.ALUOutM,            32'd0);
      check_val({tag, "_WriteDataM"}, ex_if.WriteDataM,         32'd0);
      check_val({tag, "_WriteRegM"},  {27'd0, ex_if.WriteRegM}, 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      rst_n    = 1'b0;
      drive_idle();
      #12;
      check_m_zero("reset");
      rst_n = 1'b1;
      step();

      // ADD, no forwarding, RegDst=1
      ex_if.RD1 = 32'd5; ex_if.RD2 = 32'd7; ex_if.ALUControlE = 3'b010;
      ex_if.RegDstE = 1'b1; ex_if.RdE = 5'd9; ex_if.RtE = 5'd4;
      ex_if.RegWriteE = 1'b1; ex_if.MemtoRegE = 1'b1;
      #1;
      check_val("add_WriteRegE_comb", {27'd0, ex_if.WriteRegE}, 32'd9);
      check_val("add_ALUOutM_before_edge", ex_if.ALUOutM, 32'd0);
      step();
      check_val("add_ALUOutM", ex_if.ALUOutM, 32'd12);
      check_val("add_WriteRegM", {27'd0, ex_if.WriteRegM}, 32'd9);
      check_val("add_RegWriteM", {31'd0, ex_if.RegWriteM}, 32'd1);
      check_val("add_MemtoRegM", {31'd0, ex_if.MemtoRegM}, 32'd1);
      check_val("add_WriteDataM", ex_if.WriteDataM, 32'd7);

      // SUB wraps, SLT is signed
      ex_if.RD1 = 32'd0; ex_if.RD2 = 32'd1; ex_if.ALUControlE = 3'b110;
      step();
      check_val("sub_wrap", ex_if.ALUOutM, 32'hFFFF_FFFF);
      ex_if.RD1 = 32'hFFFF_FFFF; ex_if.RD2 = 32'd1; ex_if.ALUControlE = 3'b111;
      step();
      check_val("slt_neg_lt_pos", ex_if.ALUOutM, 32'd1);
      ex_if.RD1 = 32'd1; ex_if.RD2 = 32'hFFFF_FFFF;
      step();
      check_val("slt_pos_lt_neg", ex_if.ALUOutM, 32'd0);
      ex_if.RD1 = 32'h0000_00F0; ex_if.RD2 = 32'h0000_003C; ex_if.ALUControlE = 3'b000;
      step();
      check_val("and", ex_if.ALUOutM, 32'h0000_0030);
      ex_if.ALUControlE = 3'b001;
      step();
      check_val("or", ex_if.ALUOutM, 32'h0000_00FC);

      // Back-to-back forwarding from ALUOutM
      ex_if.RD1 = 32'd3; ex_if.RD2 = 32'd4; ex_if.ALUControlE = 3'b010;
      step();
      check_val("chain_first", ex_if.ALUOutM, 32'd7);
      ex_if.ForwardAE = 2'b10; ex_if.RD1 = 32'd0; ex_if.SignImmE = 32'd1; ex_if.ALUSrcE = 1'b1;
      step();
      check_val("chain_fwdA_mem", ex_if.ALUOutM, 32'd8);
      ex_if.ForwardAE = 2'b00; ex_if.RD1 = 32'd1; ex_if.ForwardBE = 2'b10;
      ex_if.ALUSrcE = 1'b0; ex_if.RD2 = 32'd50;
      step();
      check_val("chain_fwdB_mem_alu", ex_if.ALUOutM, 32'd9);
      check_val("chain_fwdB_mem_store", ex_if.WriteDataM, 32'd8);

      // Writeback forward on B with immediate operand and store
      drive_idle();
      ex_if.ForwardBE = 2'b01; ex_if.ResultW = 32'h0000_CAFE; ex_if.ALUSrcE = 1'b1;
      ex_if.SignImmE = 32'd4; ex_if.RD1 = 32'd100; ex_if.RD2 = 32'd55;
      ex_if.MemWriteE = 1'b1; ex_if.ALUControlE = 3'b010;
      ex_if.RegDstE = 1'b0; ex_if.RtE = 5'd3; ex_if.RdE = 5'd17;
      #1;
      check_val("st_WriteRegE_rt", {27'd0, ex_if.WriteRegE}, 32'd3);
      step();
      check_val("st_ALUOutM", ex_if.ALUOutM, 32'd104);
      check_val("st_WriteDataM", ex_if.WriteDataM, 32'h0000_CAFE);
      check_val("st_MemWriteM", {31'd0, ex_if.MemWriteM}, 32'd1);
      check_val("st_RegWriteM", {31'd0, ex_if.RegWriteM}, 32'd0);
      check_val("st_WriteRegM", {27'd0, ex_if.WriteRegM}, 32'd3);

      // Bubble and undefined ALU code
      drive_idle();
      ex_if.RD1 = 32'd5; ex_if.RD2 = 32'd7; ex_if.ALUControlE = 3'b100;
      step();
      check_val("bubble_RegWriteM", {31'd0, ex_if.RegWriteM}, 32'd0);
      check_val("bubble_MemWriteM", {31'd0, ex_if.MemWriteM}, 32'd0);
      check_val("undef_op_100", ex_if.ALUOutM, 32'd0);
      ex_if.ALUControlE = 3'b011;
      step();
      check_val("undef_op_011", ex_if.ALUOutM, 32'd0);

      // Forward select 11 behaves like 00 (ALUOutM is 0, ResultW distinct)
      ex_if.ForwardAE = 2'b11; ex_if.ForwardBE = 2'b11; ex_if.ResultW = 32'd1000;
      ex_if.RD1 = 32'd20; ex_if.RD2 = 32'd1; ex_if.ALUControlE = 3'b010;
      step();
      check_val("fwd11_alu", ex_if.ALUOutM, 32'd21);
      check_val("fwd11_store", ex_if.WriteDataM, 32'd1);

      // Asynchronous reset mid-cycle, then first edge loads current inputs
      ex_if.ForwardAE = 2'b00; ex_if.ForwardBE = 2'b00;
      ex_if.RegWriteE = 1'b1; ex_if.MemtoRegE = 1'b1; ex_if.MemWriteE = 1'b1;
      ex_if.RegDstE = 1'b1; ex_if.RdE = 5'd31;
      step();
      check_val("pre_rst_ALUOutM", ex_if.ALUOutM, 32'd21);
      #2;
      rst_n = 1'b0;
      #1;
      check_m_zero("async_rst");
      #3;
      rst_n = 1'b1;
      step();
      check_val("post_rst_ALUOutM", ex_if.ALUOutM, 32'd21);
      check_val("post_rst_WriteRegM", {27'd0, ex_if.WriteRegM}, 32'd31);
      check_val("post_rst_MemWriteM", {31'd0, ex_if.MemWriteM}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
